// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW/load-use stall detection, branch flushes,
// an SRAM wait-state FSM that freezes the whole pipe, and saturating counters.
module pipe_hazard_ctrl #(
  parameter int WAIT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en_i,
  input  logic             id_valid_i,
  input  logic [3:0]       id_src1_i,
  input  logic [3:0]       id_src2_i,
  input  logic             id_two_src_i,
  input  logic [3:0]       exe_dest_i,
  input  logic             exe_wb_en_i,
  input  logic             exe_mem_r_en_i,
  input  logic [3:0]       mem_dest_i,
  input  logic             mem_wb_en_i,
  input  logic             mem_r_en_i,
  input  logic             mem_w_en_i,
  input  logic             branch_taken_i,
  output logic             pc_freeze_o,
  output logic             if_id_freeze_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             sram_freeze_o,
  output logic             mem_ready_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } sramState_e;

  sramState_e        state_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              memReady_q;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;

  logic memReq;
  logic lastWait;
  logic sramFreeze;
  logic exeMatch;
  logic memMatch;
  logic hazard;
  logic pcFreeze;

  assign memReq   = mem_r_en_i | mem_w_en_i;
  assign lastWait = (wcnt_q == WCNT_W'(WAIT_CYCLES - 1));

  // The freeze is visible in the request cycle itself, before the FSM leaves IDLE.
  assign sramFreeze = ((state_q == S_IDLE) & memReq) | (state_q == S_WAIT);

  assign exeMatch = (id_src1_i == exe_dest_i) | (id_two_src_i & (id_src2_i == exe_dest_i));
  assign memMatch = (id_src1_i == mem_dest_i) | (id_two_src_i & (id_src2_i == mem_dest_i));

  always_comb begin
    hazard = 1'b0;
    if (id_valid_i) begin
      if (fwd_en_i) begin
        hazard = exe_mem_r_en_i & exe_wb_en_i & exeMatch;
      end else begin
        hazard = (exe_wb_en_i & exeMatch) | (mem_wb_en_i & memMatch);
      end
    end
  end

  assign pcFreeze = hazard & ~branch_taken_i & ~sramFreeze;

  assign pc_freeze_o    = pcFreeze;
  assign if_id_freeze_o = pcFreeze;
  assign if_id_flush_o  = branch_taken_i & ~sramFreeze;
  assign id_ex_flush_o  = (branch_taken_i | hazard) & ~sramFreeze;
  assign sram_freeze_o  = sramFreeze;
  assign mem_ready_o    = memReady_q;

  // An access that has started always runs to DONE, even if the request drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      memReady_q <= 1'b0;
    end else begin
      memReady_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (memReq) begin
            state_q <= S_WAIT;
            wcnt_q  <= '0;
          end
        end
        S_WAIT: begin
          if (lastWait) begin
            state_q    <= S_DONE;
            memReady_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (pcFreeze && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
    if (branch_taken_i && !sramFreeze && (flushCnt_q != {CNT_W{1'b1}})) begin
      flushCnt_d = flushCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign stall_cnt_o = stallCnt_q;
  assign flush_cnt_o = flushCnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a countdown-style reference model,
// preceded by directed scenarios for stalls, flushes, SRAM freeze and saturation.
module tb_pipe_hazard_ctrl;

  localparam int WAIT_CYCLES = 4;
  localparam int CNT_W       = 5;
  localparam int MAX_CNT     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             fwdEn, idValid, idTwoSrc, exeWbEn, exeMemREn, memWbEn, memREn, memWEn, branchTaken;
  logic [3:0]       idSrc1, idSrc2, exeDest, memDest;
  logic             pcFreeze, ifIdFreeze, ifIdFlush, idExFlush, sramFreeze, memReady;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  int checks = 0;
  int fails  = 0;

  // Reference model state: remaining wait cycles, DONE-cycle flag, event counts
  int busyLeft   = 0;
  bit readyNow   = 0;
  int mStall     = 0;
  int mFlush     = 0;
  bit modelValid = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .fwd_en_i(fwdEn), .id_valid_i(idValid), .id_src1_i(idSrc1), .id_src2_i(idSrc2),
    .id_two_src_i(idTwoSrc), .exe_dest_i(exeDest), .exe_wb_en_i(exeWbEn),
    .exe_mem_r_en_i(exeMemREn), .mem_dest_i(memDest), .mem_wb_en_i(memWbEn),
    .mem_r_en_i(memREn), .mem_w_en_i(memWEn), .branch_taken_i(branchTaken),
    .pc_freeze_o(pcFreeze), .if_id_freeze_o(ifIdFreeze), .if_id_flush_o(ifIdFlush),
    .id_ex_flush_o(idExFlush), .sram_freeze_o(sramFreeze), .mem_ready_o(memReady),
    .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
  );

  task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit readsReg(input logic [3:0] r);
    return (idSrc1 == r) || (idTwoSrc && (idSrc2 == r));
  endfunction

  function automatic bit modelHazard();
    if (!idValid) return 0;
    if (fwdEn) return exeMemREn && exeWbEn && readsReg(exeDest);
    return (exeWbEn && readsReg(exeDest)) || (memWbEn && readsReg(memDest));
  endfunction

  function automatic bit modelFreeze();
    return (busyLeft > 0) || (!readyNow && (memREn || memWEn));
  endfunction

  task automatic applyStimulus(input bit r, input bit fv, input bit iv, input logic [3:0] s1,
                               input logic [3:0] s2, input bit two, input logic [3:0] ed,
                               input bit ewb, input bit emr, input logic [3:0] md, input bit mwb,
                               input bit mr, input bit mw, input bit br);
    rst = r; fwdEn = fv; idValid = iv; idSrc1 = s1; idSrc2 = s2; idTwoSrc = two;
    exeDest = ed; exeWbEn = ewb; exeMemREn = emr; memDest = md; memWbEn = mwb;
    memREn = mr; memWEn = mw; branchTaken = br;
    #3;
  endtask

  task automatic checkModel();
    bit fz, hz, stall;
    if (!modelValid) return;
    fz    = modelFreeze();
    hz    = modelHazard();
    stall = hz && !branchTaken && !fz;
    checkOutput("sram_freeze", 32'(sramFreeze), 32'(fz));
    checkOutput("pc_freeze", 32'(pcFreeze), 32'(stall));
    checkOutput("if_id_freeze", 32'(ifIdFreeze), 32'(stall));
    checkOutput("if_id_flush", 32'(ifIdFlush), 32'(branchTaken && !fz));
    checkOutput("id_ex_flush", 32'(idExFlush), 32'((branchTaken || hz) && !fz));
    checkOutput("mem_ready", 32'(memReady), 32'(readyNow));
    checkOutput("stall_cnt", 32'(stallCnt), 32'(mStall));
    checkOutput("flush_cnt", 32'(flushCnt), 32'(mFlush));
  endtask

  task automatic clockEdge();
    bit fz, hz;
    fz = modelFreeze();
    hz = modelHazard();
    @(posedge clk);
    if (rst) begin
      busyLeft = 0; readyNow = 0; mStall = 0; mFlush = 0; modelValid = 1;
    end else begin
      if (hz && !branchTaken && !fz && mStall < MAX_CNT) mStall++;
      if (branchTaken && !fz && mFlush < MAX_CNT) mFlush++;
      if (busyLeft > 0) begin
        busyLeft--;
        readyNow = (busyLeft == 0);
      end else if (readyNow) begin
        readyNow = 0;
      end else if (memREn || memWEn) begin
        busyLeft = WAIT_CYCLES;
      end
    end
    #1;
  endtask

  task automatic cycle(input bit r, input bit fv, input bit iv, input logic [3:0] s1,
                       input logic [3:0] s2, input bit two, input logic [3:0] ed, input bit ewb,
                       input bit emr, input logic [3:0] md, input bit mwb, input bit mr,
                       input bit mw, input bit br);
    applyStimulus(r, fv, iv, s1, s2, two, ed, ewb, emr, md, mwb, mr, mw, br);
    checkModel();
    clockEdge();
  endtask

  initial begin
    @(posedge clk); #1;
    repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // RAW hazard without forwarding
    applyStimulus(0, 0, 1, 3, 0, 0, 3, 1, 0, 9, 0, 0, 0, 0);
    checkOutput("t1 pc_freeze", 32'(pcFreeze), 1);
    checkOutput("t1 if_id_flush", 32'(ifIdFlush), 0);
    checkModel(); clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1 stall_cnt", 32'(stallCnt), 1);
    checkModel(); clockEdge();

    // Forwarding on: only a load in EXE stalls
    cycle(0, 1, 1, 3, 0, 0, 3, 1, 0, 9, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 3, 0, 0, 3, 1, 1, 9, 0, 0, 0, 0);
    checkOutput("t2 load-use", 32'(pcFreeze), 1);
    checkModel(); clockEdge();
    cycle(0, 1, 1, 5, 3, 1, 3, 1, 1, 9, 0, 0, 0, 0);

    // Branch wins over hazard
    applyStimulus(0, 0, 1, 3, 0, 0, 3, 1, 0, 9, 0, 0, 0, 1);
    checkOutput("t3 pc_freeze", 32'(pcFreeze), 0);
    checkModel(); clockEdge();

    // SRAM access: freeze for WAIT_CYCLES+1 cycles, ready pulse right after
    for (int c = 0; c < WAIT_CYCLES + 3; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (c == 0), 0, 0);
      checkOutput("t4 freeze", 32'(sramFreeze), 32'(c <= WAIT_CYCLES));
      checkOutput("t4 ready", 32'(memReady), 32'(c == WAIT_CYCLES + 1));
      checkModel(); clockEdge();
    end

    // Branch held during a store freeze
    for (int c = 0; c < WAIT_CYCLES + 3; c++)
      cycle(0, 0, 1, 2, 0, 0, 2, 1, 0, 0, 0, 0, (c == 0), 1);

    // Reset mid-WAIT, then drive stall counter into saturation
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6 freeze after rst", 32'(sramFreeze), 0);
    checkOutput("t6 stall_cnt after rst", 32'(stallCnt), 0);
    checkModel(); clockEdge();
    repeat (MAX_CNT + 5) cycle(0, 0, 1, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6 stall saturated", 32'(stallCnt), MAX_CNT);
    checkModel(); clockEdge();

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 2), $urandom_range(0, 1), ($urandom_range(0, 9) < 8),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom_range(0, 1),
            4'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
            4'($urandom_range(0, 3)), $urandom_range(0, 1),
            ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 15));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
